// File: rtl/timeout_recovery_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timeout_recovery_fsm_pkg
// Description : Shared definitions for the request/response timeout recovery
//               logic: state encoding, parameter defaults, helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package timeout_recovery_fsm_pkg;

    // Parameter defaults for the recovery FSM
    localparam int c_max_retry_default  = 3;
    localparam int c_rst_cycles_default = 16;

    // State encoding
    localparam int         c_state_w       = 3;
    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_wait_resp  = 3'd1;
    localparam logic [2:0] c_st_reset_chan = 3'd2;
    localparam logic [2:0] c_st_retry      = 3'd3;
    localparam logic [2:0] c_st_dead       = 3'd4;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chan_rst_stretch.sv
`default_nettype none
// ============================================================================
// Module      : chan_rst_stretch
// Description : Produces an active-low channel reset pulse exactly RST_CYCLES
//               clk cycles long, starting on the edge that samples start.
// Revision    : 1.0 - initial release
// ============================================================================
module chan_rst_stretch
    import timeout_recovery_fsm_pkg::*;
#(
    parameter int RST_CYCLES = c_rst_cycles_default
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic pulse_n
);

    // The edge that loads the counter already drives the pulse low, so the
    // counter only has to cover the remaining RST_CYCLES-1 cycles.
    localparam logic [7:0] c_load = 8'(RST_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_pulse_n;

    // Down-counter holding the pulse low; a reset truncates the pulse at once
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= 8'd0;
            r_pulse_n <= 1'b1;
        end else if (start) begin
            r_cnt     <= c_load;
            r_pulse_n <= 1'b0;
        end else if (r_cnt != 8'd0) begin
            r_cnt     <= r_cnt - 8'd1;
            r_pulse_n <= 1'b0;
        end else begin
            r_pulse_n <= 1'b1;
        end
    end

    assign pulse_n = r_pulse_n;

endmodule
`default_nettype wire

// File: rtl/timeout_recovery_fsm.sv
`default_nettype none
// ============================================================================
// Module      : timeout_recovery_fsm
// Description : Supervises one request/response transaction. On a timeout it
//               resets the channel, retries up to MAX_RETRY times and then
//               declares the channel dead until software clears it.
// Revision    : 1.0 - initial release
// ============================================================================
module timeout_recovery_fsm
    import timeout_recovery_fsm_pkg::*;
#(
    parameter int MAX_RETRY  = c_max_retry_default,
    parameter int RST_CYCLES = c_rst_cycles_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_sent,
    input  logic        resp_rcvd,
    input  logic        timeoutrst,
    input  logic        dead_clr,
    output logic        entimeout,
    output logic        chan_rst_n,
    output logic        retry_req,
    output logic        busy,
    output logic        chan_dead,
    output logic [3:0]  retry_cnt,
    output logic [15:0] timeout_cnt
);

    localparam logic [3:0] c_max_retry = 4'(MAX_RETRY);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic                 r_entimeout;
    logic                 w_entimeout_nxt;
    logic                 r_retry_req;
    logic                 w_retry_req_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_chan_dead;
    logic                 w_chan_dead_nxt;
    logic [3:0]           r_retry_cnt;
    logic [3:0]           w_retry_cnt_nxt;
    logic [15:0]          r_timeout_cnt;
    logic [15:0]          w_timeout_cnt_nxt;
    logic                 w_start;
    logic                 w_chan_rst_n;

    // Channel reset pulse generator, fired on the timeout edge
    chan_rst_stretch #(
        .RST_CYCLES (RST_CYCLES)
    ) u_chan_rst_stretch (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .pulse_n (w_chan_rst_n)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_st_idle;
            r_entimeout   <= 1'b0;
            r_retry_req   <= 1'b0;
            r_busy        <= 1'b0;
            r_chan_dead   <= 1'b0;
            r_retry_cnt   <= 4'd0;
            r_timeout_cnt <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_entimeout   <= w_entimeout_nxt;
            r_retry_req   <= w_retry_req_nxt;
            r_busy        <= w_busy_nxt;
            r_chan_dead   <= w_chan_dead_nxt;
            r_retry_cnt   <= w_retry_cnt_nxt;
            r_timeout_cnt <= w_timeout_cnt_nxt;
        end
    end

    // Next-state logic; level outputs are decoded from the next state so they
    // appear on the same edge as the transition that causes them.
    always_comb begin
        w_state_nxt       = r_state;
        w_retry_req_nxt   = 1'b0;
        w_retry_cnt_nxt   = r_retry_cnt;
        w_timeout_cnt_nxt = r_timeout_cnt;
        w_start           = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (req_sent) begin
                    w_state_nxt = c_st_wait_resp;
                end
            end
            c_st_wait_resp: begin
                // A response arriving together with the timeout still wins
                if (resp_rcvd) begin
                    w_state_nxt     = c_st_idle;
                    w_retry_cnt_nxt = 4'd0;
                end else if (timeoutrst) begin
                    w_state_nxt       = c_st_reset_chan;
                    w_timeout_cnt_nxt = sat_inc16(r_timeout_cnt);
                    w_start           = 1'b1;
                end
            end
            c_st_reset_chan: begin
                // The stretcher drives low on the entry edge, so a high level
                // seen here means the pulse has finished.
                if (w_chan_rst_n) begin
                    if (r_retry_cnt == c_max_retry) begin
                        w_state_nxt = c_st_dead;
                    end else begin
                        w_state_nxt     = c_st_retry;
                        w_retry_cnt_nxt = r_retry_cnt + 4'd1;
                    end
                end
            end
            c_st_retry: begin
                // Hold off until the timer has dropped its limit flag
                if (!timeoutrst) begin
                    w_state_nxt     = c_st_wait_resp;
                    w_retry_req_nxt = 1'b1;
                end
            end
            c_st_dead: begin
                if (dead_clr) begin
                    w_state_nxt     = c_st_idle;
                    w_retry_cnt_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        w_entimeout_nxt = (w_state_nxt == c_st_wait_resp);
        w_busy_nxt      = (w_state_nxt != c_st_idle) && (w_state_nxt != c_st_dead);
        w_chan_dead_nxt = (w_state_nxt == c_st_dead);
    end

    assign entimeout   = r_entimeout;
    assign chan_rst_n  = w_chan_rst_n;
    assign retry_req   = r_retry_req;
    assign busy        = r_busy;
    assign chan_dead   = r_chan_dead;
    assign retry_cnt   = r_retry_cnt;
    assign timeout_cnt = r_timeout_cnt;

endmodule
`default_nettype wire
